// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: handshaked driver for a combinational ALU.
// Accepts a command, drives the ALU, waits SETTLE_CYCLES edges,
// then captures the result and flags into a held response.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   cmd_valid/ready     command handshake; cmd_op/cmd_a/cmd_b payload
//   alu_a/alu_b/alu_op  registered operands and opcode to the ALU
//   alu_out/alu_n/alu_z ALU result and N/Z flags
//   rsp_valid/ready     response handshake
//   rsp_result/n/z/op   captured result, flags and opcode
//   rsp_illegal         opcode was outside 0..4
//   rsp_mismatch        golden-model mismatch (0 unless checking is on)
//
// Optional: define ALU_SEQ_CHECK_EN to build the golden-model checker.

module alu_cmd_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_n,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_n,
    output logic             rsp_z,
    output logic [3:0]       rsp_op,
    output logic             rsp_illegal,
    output logic             rsp_mismatch
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_cfg
        $error("alu_cmd_sequencer: SETTLE_CYCLES must be 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_n_q, rsp_n_d;
    logic             rsp_z_q, rsp_z_d;
    logic [3:0]       rsp_op_q, rsp_op_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    logic op_legal;
    logic accept;
    logic capture;

    assign op_legal = (cmd_op <= 4'd4);
    assign accept   = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign capture  = (state_q == S_SETTLE) && (cnt_q == 4'd0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_n_d       = rsp_n_q;
        rsp_z_d       = rsp_z_q;
        rsp_op_d      = rsp_op_q;
        rsp_illegal_d = rsp_illegal_q;

        unique case (state_q)
            S_IDLE: begin
                // Ready rises on the first edge after reset release.
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    if (op_legal) begin
                        alu_a_d  = cmd_a;
                        alu_b_d  = cmd_b;
                        alu_op_d = cmd_op;
                        cnt_d    = CNT_INIT;
                        state_d  = S_SETTLE;
                    end else begin
                        // Respond at once; the ALU keeps its last inputs.
                        rsp_valid_d   = 1'b1;
                        rsp_result_d  = '0;
                        rsp_n_d       = 1'b0;
                        rsp_z_d       = 1'b0;
                        rsp_op_d      = cmd_op;
                        rsp_illegal_d = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end
            S_SETTLE: begin
                if (capture) begin
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = alu_out;
                    rsp_n_d       = alu_n;
                    rsp_z_d       = alu_z;
                    rsp_op_d      = alu_op_q;
                    rsp_illegal_d = 1'b0;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            cmd_ready_q   <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= 4'd0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_n_q       <= 1'b0;
            rsp_z_q       <= 1'b0;
            rsp_op_q      <= 4'd0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_n_q       <= rsp_n_d;
            rsp_z_q       <= rsp_z_d;
            rsp_op_q      <= rsp_op_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_result;
    logic             mismatch_now;
    logic             rsp_mismatch_q, rsp_mismatch_d;

    // Reference model evaluated on the registered ALU inputs.
    always_comb begin
        exp_result = '0;
        unique case (alu_op_q)
            4'd0:    exp_result = alu_a_q + alu_b_q;
            4'd1:    exp_result = alu_a_q + {{(WIDTH-1){1'b0}}, 1'b1};
            4'd2:    exp_result = '0 - alu_a_q;
            4'd3:    exp_result = alu_a_q - alu_b_q;
            4'd4:    exp_result = alu_a_q;
            default: exp_result = '0;
        endcase
    end

    assign mismatch_now = (exp_result != alu_out)
                       || (exp_result[WIDTH-1] != alu_n)
                       || ((exp_result == '0) != alu_z);

    always_comb begin
        rsp_mismatch_d = rsp_mismatch_q;
        if (capture) begin
            rsp_mismatch_d = mismatch_now;
        end else if (accept && !op_legal) begin
            rsp_mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_mismatch_q <= 1'b0;
        end else begin
            rsp_mismatch_q <= rsp_mismatch_d;
        end
    end

    assign rsp_mismatch = rsp_mismatch_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

    assign cmd_ready   = cmd_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_n       = rsp_n_q;
    assign rsp_z       = rsp_z_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer.
// Includes a combinational ALU with an injectable add fault.

module tb_alu_cmd_sequencer;

    localparam int W = 32;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic MM_FAULT = 1'b1;
`else
    localparam logic MM_FAULT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_out;
    logic         alu_n;
    logic         alu_z;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_n;
    logic         rsp_z;
    logic [3:0]   rsp_op;
    logic         rsp_illegal;
    logic         rsp_mismatch;
    logic         fault_add;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .WIDTH(W),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_out(alu_out),
        .alu_n(alu_n),
        .alu_z(alu_z),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_n(rsp_n),
        .rsp_z(rsp_z),
        .rsp_op(rsp_op),
        .rsp_illegal(rsp_illegal),
        .rsp_mismatch(rsp_mismatch)
    );

    // Bench ALU; fault_add flips bit 0 of the add result.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            4'd0: alu_out = (alu_a + alu_b) ^ {{(W-1){1'b0}}, fault_add};
            4'd1: alu_out = alu_a + 32'd1;
            4'd2: alu_out = 32'd0 - alu_a;
            4'd3: alu_out = alu_a - alu_b;
            4'd4: alu_out = alu_a;
            default: alu_out = '0;
        endcase
        alu_n = alu_out[W-1];
        alu_z = (alu_out == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 4'd0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b0;
        fault_add = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_n, rsp_z, rsp_illegal,
             rsp_mismatch} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {cmd_ready, rsp_valid, rsp_n, rsp_z,
                      rsp_illegal, rsp_mismatch});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_op} !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h op=%h r=%h rop=%h want 0",
                     alu_a, alu_b, alu_op, rsp_result, rsp_op);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 0", cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 4'd0;
        cmd_a = 32'hFFFF_FFD8;
        cmd_b = 32'h0000_000C;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (alu_a !== 32'hFFFF_FFD8 || alu_b !== 32'hC || alu_op !== 4'd0
            || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_drive: a=%h b=%h op=%h rdy=%b",
                     alu_a, alu_b, alu_op, cmd_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early_valid: got %b want 0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFF_FFE4
            || rsp_n !== 1'b1 || rsp_z !== 1'b0 || rsp_op !== 4'd0
            || rsp_illegal !== 1'b0 || rsp_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp: v=%b r=%h n=%b z=%b op=%h il=%b mm=%b want 1 ffffffe4 1 0 0 0 0",
                     rsp_valid, rsp_result, rsp_n, rsp_z, rsp_op,
                     rsp_illegal, rsp_mismatch);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_done: v=%b rdy=%b want 0 1",
                     rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_opcode_sweep();
        logic [3:0] ops [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        logic [W-1:0] res [4] = '{32'h15, 32'hFFFF_FFEC, 32'h0, 32'h14};
        logic [1:0] nz [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_op = ops[i];
            cmd_a = 32'h14;
            cmd_b = 32'h14;
            tick();
            cmd_valid = 1'b0;
            checks++;
            if (cmd_ready !== 1'b0 || alu_op !== ops[i]) begin
                errors++;
                $display("FAIL sweep_accept op=%h: rdy=%b aop=%h",
                         ops[i], cmd_ready, alu_op);
            end
            tick();
            checks++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL sweep_settle op=%h: rdy=%b v=%b want 0 0",
                         ops[i], cmd_ready, rsp_valid);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0
                || rsp_result !== res[i] || {rsp_n, rsp_z} !== nz[i]
                || rsp_op !== ops[i] || rsp_illegal !== 1'b0) begin
                errors++;
                $display("FAIL sweep_rsp op=%h: v=%b rdy=%b r=%h nz=%b rop=%h want r=%h nz=%b",
                         ops[i], rsp_valid, cmd_ready, rsp_result,
                         {rsp_n, rsp_z}, rsp_op, res[i], nz[i]);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_done op=%h: v=%b rdy=%b want 0 1",
                         ops[i], rsp_valid, cmd_ready);
            end
        end
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 4'd7;
        cmd_a = 32'h99;
        cmd_b = 32'h77;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1
            || rsp_result !== 32'h0 || rsp_n !== 1'b0 || rsp_z !== 1'b0
            || rsp_op !== 4'd7 || rsp_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL illegal_rsp: v=%b il=%b r=%h n=%b z=%b op=%h mm=%b",
                     rsp_valid, rsp_illegal, rsp_result, rsp_n, rsp_z,
                     rsp_op, rsp_mismatch);
        end
        checks++;
        if (alu_a !== 32'h14 || alu_b !== 32'h14 || alu_op !== 4'd4) begin
            errors++;
            $display("FAIL illegal_alu_hold: a=%h b=%h op=%h want 14 14 4",
                     alu_a, alu_b, alu_op);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_done: v=%b rdy=%b want 0 1",
                     rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 4'd3;
        cmd_a = 32'd5;
        cmd_b = 32'd3;
        tick();
        cmd_op = 4'd0;
        cmd_a = 32'd7;
        cmd_b = 32'd1;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd2) begin
            errors++;
            $display("FAIL bp_first_rsp: v=%b r=%h want 1 2",
                     rsp_valid, rsp_result);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd2
                || rsp_op !== 4'd3 || cmd_ready !== 1'b0
                || alu_a !== 32'd5) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: v=%b r=%h op=%h rdy=%b a=%h",
                         i, rsp_valid, rsp_result, rsp_op, cmd_ready,
                         alu_a);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 32'd5) begin
            errors++;
            $display("FAIL bp_handshake: v=%b rdy=%b a=%h want 0 1 5",
                     rsp_valid, cmd_ready, alu_a);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || alu_a !== 32'd7 || alu_op !== 4'd0) begin
            errors++;
            $display("FAIL bp_second_accept: rdy=%b a=%h op=%h want 0 7 0",
                     cmd_ready, alu_a, alu_op);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd8 || rsp_op !== 4'd0) begin
            errors++;
            $display("FAIL bp_second_rsp: v=%b r=%h op=%h want 1 8 0",
                     rsp_valid, rsp_result, rsp_op);
        end
        tick();
    endtask

    task automatic test_reset_mid_settle();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 4'd0;
        cmd_a = 32'd10;
        cmd_b = 32'd20;
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b00 || alu_a !== '0
            || alu_b !== '0 || rsp_result !== '0) begin
            errors++;
            $display("FAIL abort_clear: rdy=%b v=%b a=%h b=%h r=%h",
                     cmd_ready, rsp_valid, alu_a, alu_b, rsp_result);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b want 1", cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_rsp cyc%0d: v=%b want 0",
                         i, rsp_valid);
            end
        end
    endtask

    task automatic test_mismatch();
        rsp_ready = 1'b1;
        fault_add = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 4'd0;
        cmd_a = 32'd3;
        cmd_b = 32'd4;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd6
            || rsp_mismatch !== MM_FAULT) begin
            errors++;
            $display("FAIL mm_fault: v=%b r=%h mm=%b want 1 6 %b",
                     rsp_valid, rsp_result, rsp_mismatch, MM_FAULT);
        end
        tick();
        fault_add = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd7
            || rsp_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mm_good: v=%b r=%h mm=%b want 1 7 0",
                     rsp_valid, rsp_result, rsp_mismatch);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_opcode_sweep();
        test_illegal();
        test_backpressure();
        test_reset_mid_settle();
        test_mismatch();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
